mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter_pick.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the IF / load-store memory port arbiter:
//   - FSM state encoding (IDLE, ISSUE, WAIT, DONE)
//   - owner encoding (OWN_IF, OWN_D)
//   - default parameter values
//   - cnt_w(): width of a counter that must hold 0..maxval
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int AW_DEF         = 32;
  localparam int DW_DEF         = 32;
  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;

  function automatic int cnt_w(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the two requester handshakes, the memory macro port and busy.
//   slave  : the arbiter side (takes requests and mem_rdata, drives the rest)
//   master : the environment side (the CPU requesters plus the memory model)
// Parameters: AW address width, DW data width.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  // instruction-fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  // load/store requester
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  // memory macro
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // status
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick
// Combinational winner select between the IF and D requesters.
// Build option ARB_RR_EN:
//   undefined : fixed priority, D wins a tie unless the starvation counter
//               has reached STARVE_MAX, then IF wins.
//   defined   : round-robin, a tie goes to the requester that did not own
//               the previous transfer; the starvation input is removed.
// Ports:
//   i_if_req, i_d_req  request lines
//   i_last_owner       owner of the most recent grant (OWN_IF / OWN_D)
//   i_starve_cnt       consecutive D grants with IF waiting (fixed priority only)
//   o_any              at least one request present
//   o_winner           selected owner, meaningful only when o_any=1
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int SW         = cnt_w(STARVE_MAX_DEF)
)(
  input  logic          i_if_req,
  input  logic          i_d_req,
  input  logic          i_last_owner,
`ifndef ARB_RR_EN
  input  logic [SW-1:0] i_starve_cnt,
`endif
  output logic          o_any,
  output logic          o_winner
);

  assign o_any = i_if_req | i_d_req;

`ifdef ARB_RR_EN
  always_comb begin
    o_winner = OWN_D;
    if (i_if_req && i_d_req) begin
      o_winner = ~i_last_owner;
    end else if (i_if_req) begin
      o_winner = OWN_IF;
    end
  end
`else
  // Last owner only matters for round-robin.
  logic w_unused_last;
  assign w_unused_last = i_last_owner;

  always_comb begin
    o_winner = OWN_D;
    if (i_if_req && i_d_req) begin
      o_winner = (i_starve_cnt == SW'(STARVE_MAX)) ? OWN_IF : OWN_D;
    end else if (i_if_req) begin
      o_winner = OWN_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch path (IF) and
// the load/store path (D) of a multicycle CPU. Each transfer walks
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
//   IDLE  : arbitrate; winner's gnt is combinational, request is latched.
//   ISSUE : mem_en for exactly one cycle.
//   WAIT  : count MEM_LAT; mem_rdata captured on the last WAIT cycle.
//   DONE  : owner's done pulse.
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous active-high reset (abandons any transfer in flight)
//   bus  mem_port_arbiter_if.slave: IF/D handshakes, memory port, busy
// Parameters: AW, DW, MEM_LAT (>=1), STARVE_MAX.
// Build option ARB_RR_EN: round-robin tie-break instead of fixed priority
// with starvation guard (see mem_arb_pick).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
)(
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.slave   bus
);

  localparam int CW = cnt_w(MEM_LAT);
  localparam int SW = cnt_w(STARVE_MAX);

  logic [1:0]    r_state;
  logic          r_own;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_last_owner;

  logic          w_any;
  logic          w_winner;
  logic          w_arb;

`ifndef ARB_RR_EN
  logic [SW-1:0] r_starve;
`endif

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .i_if_req     (bus.if_req),
    .i_d_req      (bus.d_req),
    .i_last_owner (r_last_owner),
`ifndef ARB_RR_EN
    .i_starve_cnt (r_starve),
`endif
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  // A grant happens only in IDLE; masked by RST so every output is 0 while
  // reset is held, even with requests pending.
  assign w_arb = (r_state == ST_IDLE) & w_any & ~RST;

  assign bus.if_gnt    = w_arb & (w_winner == OWN_IF);
  assign bus.d_gnt     = w_arb & (w_winner == OWN_D);
  assign bus.mem_en    = (r_state == ST_ISSUE);
  assign bus.mem_we    = (r_state == ST_ISSUE) & r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.if_done   = (r_state == ST_DONE) & (r_own == OWN_IF);
  assign bus.d_done    = (r_state == ST_DONE) & (r_own == OWN_D);
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.busy      = (r_state != ST_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_own        <= OWN_IF;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_last_owner <= OWN_IF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb) begin
            r_own        <= w_winner;
            r_last_owner <= w_winner;
            if (w_winner == OWN_D) begin
              r_we    <= bus.d_we;
              r_addr  <= bus.d_addr;
              r_wdata <= bus.d_wdata;
            end else begin
              // Fetches never write; wdata keeps its last value.
              r_we    <= 1'b0;
              r_addr  <= bus.if_addr;
            end
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= CW'(MEM_LAT);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Count 1 marks cycle issue+MEM_LAT, where mem_rdata is valid.
          if (r_cnt == CW'(1)) begin
            if (r_own == OWN_IF) begin
              r_if_rdata <= bus.mem_rdata;
            end else if (!r_we) begin
              r_d_rdata  <= bus.mem_rdata;
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef ARB_RR_EN
  // Consecutive D grants taken while IF was waiting; saturates at
  // STARVE_MAX, which forces the next tie to IF.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_starve <= '0;
    end else if (w_arb) begin
      if (w_winner == OWN_IF) begin
        r_starve <= '0;
      end else if (bus.if_req && (r_starve != SW'(STARVE_MAX))) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: reset values, a table of single
// transfers, hand-written multi-cycle sequences (exact IF timing, store
// behaviour, reset mid-transfer, tie-break pattern) and a randomized run
// against a transaction-level schedule model. Honours ARB_RR_EN.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int NRAND      = 2000;

  logic CLK;
  logic RST;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW         (32),
    .DW         (32),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk1 ({nm, "_if_gnt"},   bus.if_gnt,    1'b0);
    chk1 ({nm, "_d_gnt"},    bus.d_gnt,     1'b0);
    chk1 ({nm, "_if_done"},  bus.if_done,   1'b0);
    chk1 ({nm, "_d_done"},   bus.d_done,    1'b0);
    chk32({nm, "_if_rdata"}, bus.if_rdata,  32'h0);
    chk32({nm, "_d_rdata"},  bus.d_rdata,   32'h0);
    chk1 ({nm, "_mem_en"},   bus.mem_en,    1'b0);
    chk1 ({nm, "_mem_we"},   bus.mem_we,    1'b0);
    chk32({nm, "_mem_addr"}, bus.mem_addr,  32'h0);
    chk32({nm, "_mem_wd"},   bus.mem_wdata, 32'h0);
    chk1 ({nm, "_busy"},     bus.busy,      1'b0);
  endtask

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mrd;
    logic        exp_if;     // 1: IF wins, 0: D wins
    logic [31:0] exp_maddr;
    logic        exp_mwe;
    logic [31:0] exp_rdata;  // owner's rdata after done
  } vec_t;

  vec_t vt [6];

  initial begin
    int          n;
    int          en_cnt;
    int          bad;
    logic        got;
    logic        grant_d [10];
    int          grant_cyc [10];
    int          ng;
    int          cyc;

    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         32'h2001_0001, 1'b1, 32'h0000_0010, 1'b0, 32'h2001_0001};
    vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0044, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0000_0044, 1'b0, 32'hCAFE_F00D};
    vt[2] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0040, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'h0000_0040, 1'b1, 32'h0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0090, 32'h0000_0080, 32'h0,         32'h0000_A5A5, 1'b0, 32'h0000_0080, 1'b0, 32'h0000_A5A5};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0094, 32'h0000_0084, 32'h5555_AAAA, 32'h7777_7777, 1'b0, 32'h0000_0084, 1'b1, 32'h0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFF};

    // Reset state, with both requests high to show grants are held off.
    clear_inputs();
    RST = 1'b1;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    do_reset();

    // Single transfers from a fresh IDLE.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.if_req    = vt[i].if_req;
      bus.if_addr   = vt[i].if_addr;
      bus.d_req     = vt[i].d_req;
      bus.d_we      = vt[i].d_we;
      bus.d_addr    = vt[i].d_addr;
      bus.d_wdata   = vt[i].d_wdata;
      bus.mem_rdata = vt[i].mrd;
      @(negedge CLK);
      chk1("tbl_if_gnt", bus.if_gnt, vt[i].exp_if);
      chk1("tbl_d_gnt",  bus.d_gnt,  ~vt[i].exp_if);
      tick();
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      @(negedge CLK);
      chk1 ("tbl_mem_en",   bus.mem_en,   1'b1);
      chk1 ("tbl_mem_we",   bus.mem_we,   vt[i].exp_mwe);
      chk32("tbl_mem_addr", bus.mem_addr, vt[i].exp_maddr);
      if (vt[i].exp_mwe) chk32("tbl_mem_wdata", bus.mem_wdata, vt[i].d_wdata);
      n   = 1;
      got = 1'b0;
      while (!got && n < 20) begin
        tick();
        n++;
        @(negedge CLK);
        if (bus.if_done || bus.d_done) got = 1'b1;
      end
      chk32("tbl_done_lat", n, MEM_LAT + 2);
      chk1 ("tbl_if_done", bus.if_done, vt[i].exp_if);
      chk1 ("tbl_d_done",  bus.d_done,  ~vt[i].exp_if);
      chk32("tbl_rdata", vt[i].exp_if ? bus.if_rdata : bus.d_rdata, vt[i].exp_rdata);
    end

    // Exact IF timing: mem_rdata is valid only in cycle T+1+MEM_LAT.
    do_reset();
    bus.mem_rdata = 32'h0BAD_0BAD;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h10;
    @(negedge CLK);
    chk1("ift_gnt", bus.if_gnt, 1'b1);
    tick();
    bus.if_req = 1'b0;
    @(negedge CLK);
    chk1 ("ift_mem_en",   bus.mem_en,   1'b1);
    chk32("ift_mem_addr", bus.mem_addr, 32'h10);
    chk1 ("ift_mem_we",   bus.mem_we,   1'b0);
    for (int k = 2; k <= MEM_LAT + 1; k++) begin
      tick();
      bus.mem_rdata = (k == MEM_LAT + 1) ? 32'h2001_0001 : 32'h0BAD_0BAD;
      @(negedge CLK);
      chk1("ift_no_early_done", bus.if_done, 1'b0);
      chk1("ift_wait_mem_en",   bus.mem_en,  1'b0);
    end
    tick();
    bus.mem_rdata = 32'h0BAD_0BAD;
    @(negedge CLK);
    chk1 ("ift_done",  bus.if_done,  1'b1);
    chk32("ift_rdata", bus.if_rdata, 32'h2001_0001);
    chk1 ("ift_busy",  bus.busy,     1'b1);
    tick();
    @(negedge CLK);
    chk1 ("ift_done_pulse", bus.if_done,  1'b0);
    chk32("ift_rdata_hold", bus.if_rdata, 32'h2001_0001);
    chk1 ("ift_idle",       bus.busy,     1'b0);

    // Load then store: store strobes once, d_rdata keeps the load value.
    do_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
    bus.mem_rdata = 32'h1122_3344;
    tick();
    bus.d_req = 1'b0;
    repeat (MEM_LAT + 3) tick();
    bus.mem_rdata = 32'h9999_9999;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk1("st_gnt", bus.d_gnt, 1'b1);
    tick();
    bus.d_req = 1'b0;
    en_cnt = 0;
    bad    = 0;
    got    = 1'b0;
    n      = 1;
    for (int k = 0; k < MEM_LAT + 4; k++) begin
      @(negedge CLK);
      if (bus.mem_en) begin
        en_cnt++;
        if (!bus.mem_we || bus.mem_addr != 32'h40 || bus.mem_wdata != 32'hDEAD_BEEF) bad++;
      end
      if (bus.d_done && !got) begin
        got = 1'b1;
        chk32("st_done_lat", n, MEM_LAT + 2);
      end
      tick();
      n++;
    end
    chk32("st_en_cycles", en_cnt, 1);
    chk32("st_en_fields", bad, 0);
    chk1 ("st_done_seen", got, 1'b1);
    chk32("st_d_rdata",   bus.d_rdata, 32'h1122_3344);

    // Reset in the middle of an IF read's WAIT phase.
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.mem_rdata = 32'h3333_3333;
    tick();
    bus.if_req = 1'b0;
    tick();
    #2;
    RST = 1'b1;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    #1;
    chk_all_zero("rstmid");
    tick();
    RST = 1'b0;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bad = 0;
    for (int k = 0; k < MEM_LAT + 4; k++) begin
      @(negedge CLK);
      if (bus.if_done || bus.mem_en || bus.busy) bad++;
      tick();
    end
    chk32("rstmid_quiet", bad, 0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h30;
    @(negedge CLK);
    chk1("rstmid_regrant", bus.if_gnt, 1'b1);
    tick();
    bus.if_req = 1'b0;
    @(negedge CLK);
    chk32("rstmid_addr", bus.mem_addr, 32'h30);
    chk32("rstmid_rdata", bus.if_rdata, 32'h0);
    repeat (MEM_LAT + 3) tick();

    // Both requesters held high: tie-break pattern and back-to-back grants.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.d_req  = 1'b1; bus.d_addr  = 32'h200; bus.d_we = 1'b0;
    ng  = 0;
    cyc = 0;
    while (ng < 10 && cyc < 10 * (MEM_LAT + 3) + 20) begin
      @(negedge CLK);
      if (bus.if_gnt || bus.d_gnt) begin
        grant_d[ng]   = bus.d_gnt;
        grant_cyc[ng] = cyc;
        ng++;
      end
      tick();
      cyc++;
    end
    chk32("tie_grant_count", ng, 10);
    for (int g = 0; g < ng; g++) begin
`ifdef ARB_RR_EN
      chk1("tie_rr_owner", grant_d[g], (g % 2) == 0);
`else
      chk1("tie_fp_owner", grant_d[g], (g % (STARVE_MAX + 1)) != STARVE_MAX);
`endif
      if (g > 0) chk32("tie_gap", grant_cyc[g] - grant_cyc[g-1], MEM_LAT + 3);
    end
    clear_inputs();
    repeat (MEM_LAT + 3) tick();

    // Randomized run against a transaction schedule model.
    do_reset();
    begin
      int          m_free, m_T, m_starve;
      logic        m_own_d, m_we, m_last_d;
      logic [31:0] m_addr, m_wdata, m_if_rd, m_d_rd;
      logic        if_pend, d_pend, dwe, win_d, gw;
      logic [31:0] ifa, da, dwd, rd_now;
      logic        e_en, e_ifd, e_dd;
      m_free = 0; m_T = -100; m_starve = 0;
      m_own_d = 1'b0; m_we = 1'b0; m_last_d = 1'b0;
      m_addr = '0; m_wdata = '0; m_if_rd = '0; m_d_rd = '0;
      if_pend = 1'b0; d_pend = 1'b0; dwe = 1'b0;
      ifa = '0; da = '0; dwd = '0;
      for (int c = 0; c < NRAND; c++) begin
        if (!if_pend && $urandom_range(0, 2) == 0) begin
          if_pend = 1'b1;
          ifa     = $urandom;
        end
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          d_pend = 1'b1;
          da     = $urandom;
          dwd    = $urandom;
          dwe    = 1'($urandom_range(0, 1));
        end
        rd_now        = $urandom;
        bus.if_req    = if_pend;
        bus.if_addr   = ifa;
        bus.d_req     = d_pend;
        bus.d_addr    = da;
        bus.d_wdata   = dwd;
        bus.d_we      = dwe;
        bus.mem_rdata = rd_now;

        e_en  = (c == m_T + 1);
        e_ifd = (c == m_T + 2 + MEM_LAT) && !m_own_d;
        e_dd  = (c == m_T + 2 + MEM_LAT) &&  m_own_d;
        gw    = 1'b0;
        win_d = 1'b0;
        if (c >= m_free && (if_pend || d_pend)) begin
          gw = 1'b1;
          if (if_pend && d_pend) begin
`ifdef ARB_RR_EN
            win_d = !m_last_d;
`else
            win_d = (m_starve < STARVE_MAX);
`endif
          end else begin
            win_d = d_pend;
          end
        end

        @(negedge CLK);
        chk1 ("rnd_if_gnt",   bus.if_gnt,   gw && !win_d);
        chk1 ("rnd_d_gnt",    bus.d_gnt,    gw &&  win_d);
        chk1 ("rnd_mem_en",   bus.mem_en,   e_en);
        chk1 ("rnd_mem_we",   bus.mem_we,   e_en && m_we);
        chk32("rnd_mem_addr", bus.mem_addr, m_addr);
        if (e_en && m_we) chk32("rnd_mem_wdata", bus.mem_wdata, m_wdata);
        chk1 ("rnd_busy",     bus.busy,     c < m_free);
        chk1 ("rnd_if_done",  bus.if_done,  e_ifd);
        chk1 ("rnd_d_done",   bus.d_done,   e_dd);
        chk32("rnd_if_rdata", bus.if_rdata, m_if_rd);
        chk32("rnd_d_rdata",  bus.d_rdata,  m_d_rd);

        if (c == m_T + 1 + MEM_LAT) begin
          if (!m_own_d) m_if_rd = rd_now;
          else if (!m_we) m_d_rd = rd_now;
        end
        if (gw) begin
          m_T      = c;
          m_free   = c + MEM_LAT + 3;
          m_own_d  = win_d;
          m_we     = win_d && dwe;
          m_addr   = win_d ? da : ifa;
          if (win_d) m_wdata = dwd;
          m_last_d = win_d;
          if (!win_d) m_starve = 0;
          else if (if_pend && m_starve < STARVE_MAX) m_starve++;
          if (win_d) d_pend = 1'b0;
          else       if_pend = 1'b0;
        end
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
